// File: rtl/tdc_meas_ctrl_if.sv
// tdc_meas_ctrl_if: result FIFO read port between tdc_meas_ctrl and the SPI register block.
interface tdc_meas_ctrl_if;
  logic [25:0] res_data;
  logic res_valid;
  logic res_pop;
  modport master (output res_data, res_valid, input res_pop);
  modport slave (input res_data, res_valid, output res_pop);
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: sequences TDC measurements into a result FIFO with timeout recovery.
// Defining TDC_MEAS_STATS_EN adds min/max/error statistics outputs.
module tdc_meas_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_W = 16,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_start,
  input  logic cmd_stop,
  input  logic [7:0] cfg_count,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic meas_arm,
  output logic tdc_clear,
  input  logic tdc_busy,
  input  logic [31:0] tdc_coarse,
  input  logic [8:0] tdc_fine,
  tdc_meas_ctrl_if.master res,
  output logic run_active,
  output logic [7:0] meas_done_cnt,
  output logic overflow_stall
`ifdef TDC_MEAS_STATS_EN
  ,
  output logic [24:0] stat_min,
  output logic [24:0] stat_max,
  output logic [7:0] stat_err_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [25:0] ERR_ENTRY = {1'b1, 16'hFFFF, 9'h1FF};
  typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, MEASURE, CAPTURE, CLEAR} state_t;
  state_t state;
  logic busy_m, busy_s;
  logic [TIMEOUT_W-1:0] tmo, timeout_r;
  logic [7:0] count_r, done_next;
  logic stop_l;
  logic [CW-1:0] clr_cnt;
  logic [25:0] entry;
  logic [25:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fill;
  logic full, pop, can_push, push, run_end;
  logic [15:0] coarse_sat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {busy_s, busy_m} <= 2'b00;
    else {busy_s, busy_m} <= {busy_m, tdc_busy};
  always_comb begin
    coarse_sat = |tdc_coarse[31:16] ? 16'hFFFF : tdc_coarse[15:0];
    full = fill == (AW+1)'(FIFO_DEPTH);
    pop = res.res_pop && fill != '0;
    can_push = !full || pop;
    push = can_push && (state == CAPTURE || (state == CLEAR && clr_cnt == '0));
    done_next = meas_done_cnt + 8'd1;
    run_end = (count_r != 8'd0 && done_next == count_r) || stop_l || cmd_stop;
  end
  assign res.res_valid = fill != '0;
  assign res.res_data = res.res_valid ? mem[rd_ptr] : '0;
  assign run_active = state != IDLE;
  assign overflow_stall = state == CAPTURE && full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= entry;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      meas_arm <= 1'b0;
      tdc_clear <= 1'b0;
      tmo <= '0;
      timeout_r <= '0;
      count_r <= '0;
      stop_l <= 1'b0;
      clr_cnt <= '0;
      entry <= '0;
      meas_done_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (cmd_start && !cmd_stop) begin
            state <= ARM;
            meas_done_cnt <= '0;
            count_r <= cfg_count;
            timeout_r <= cfg_timeout;
            stop_l <= 1'b0;
          end
        ARM:
          if (cmd_stop) state <= IDLE;
          else begin
            state <= WAIT_BUSY;
            meas_arm <= 1'b1;
            tmo <= timeout_r;
          end
        WAIT_BUSY:
          if (cmd_stop) begin
            state <= IDLE;
            meas_arm <= 1'b0;
          end else if (busy_s) begin
            state <= MEASURE;
            meas_arm <= 1'b0;
            tmo <= timeout_r;
          end else if (tmo == '0) begin
            state <= CLEAR;
            meas_arm <= 1'b0;
            tdc_clear <= 1'b1;
            clr_cnt <= CW'(CLEAR_CYCLES - 1);
            entry <= ERR_ENTRY;
          end else tmo <= tmo - 1'b1;
        MEASURE: begin
          stop_l <= stop_l | cmd_stop;
          if (!busy_s) begin
            state <= CAPTURE;
            entry <= {1'b0, coarse_sat, tdc_fine};
          end else if (tmo == '0) begin
            state <= CLEAR;
            tdc_clear <= 1'b1;
            clr_cnt <= CW'(CLEAR_CYCLES - 1);
            entry <= ERR_ENTRY;
          end else tmo <= tmo - 1'b1;
        end
        CAPTURE: begin
          stop_l <= stop_l | cmd_stop;
          if (push) begin
            meas_done_cnt <= done_next;
            state <= run_end ? IDLE : ARM;
          end
        end
        CLEAR: begin
          stop_l <= stop_l | cmd_stop;
          if (clr_cnt != '0) clr_cnt <= clr_cnt - 1'b1;
          else tdc_clear <= 1'b0;
          if (push) begin
            meas_done_cnt <= done_next;
            state <= run_end ? IDLE : ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef TDC_MEAS_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_err_cnt <= '0;
    end else if (state == IDLE && cmd_start) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_err_cnt <= '0;
    end else if (push) begin
      if (entry[25]) stat_err_cnt <= stat_err_cnt + {7'd0, stat_err_cnt != 8'hFF};
      else begin
        if (entry[24:0] < stat_min) stat_min <= entry[24:0];
        if (entry[24:0] > stat_max) stat_max <= entry[24:0];
      end
    end
`endif
endmodule
